// File: rtl/miinst_queue_pkg.sv
// rtl/miinst_queue_pkg.sv - micro-instruction types and the NOP constructor
// Purpose: shared types for the micro-instruction queue slice.
//   reg_t    : architectural register / PC width
//   uop_e    : micro-op class
//   miinst_t : one translated micro-instruction
//   nop(pc)  : well-formed NOP carrying a given PC
package miinst_queue_pkg;

  localparam int XLEN  = 32;
  localparam int REG_N = 16;
  localparam int REG_W = $clog2(REG_N);
  localparam int RIP   = REG_N - 1;

  typedef logic [XLEN-1:0] reg_t;

  typedef enum logic [3:0] {
    UOP_NOP    = 4'd0,
    UOP_ALU    = 4'd1,
    UOP_LOAD   = 4'd2,
    UOP_STORE  = 4'd3,
    UOP_BRANCH = 4'd4,
    UOP_MOVI   = 4'd5
  } uop_e;

  typedef struct packed {
    uop_e             op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    reg_t             imm;
    reg_t             pc;
  } miinst_t;

  function automatic miinst_t nop(input reg_t pc);
    miinst_t m;
    m    = '0;
    m.op = UOP_NOP;
    m.pc = pc;
    return m;
  endfunction

endpackage

// File: rtl/miinst_queue_if.sv
// rtl/miinst_queue_if.sv - translator/decode handshake bundle for the micro-op queue
// Purpose: groups the enqueue and head/dequeue signals of miinst_queue.
//   master : translator + decode side (drives enq_miinst, enq_num, stall, flush)
//   slave  : the queue (drives enq_ready, deq_miinst_head, deq_valid, count)
interface miinst_queue_if
  import miinst_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ENQ_N = 2
);

  localparam int NUM_W = $clog2(ENQ_N + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  miinst_t [ENQ_N-1:0] enq_miinst;
  logic [NUM_W-1:0]    enq_num;
  logic                enq_ready;
  miinst_t             deq_miinst_head;
  logic                deq_valid;
  logic                stall;
  logic                flush;
  logic [CNT_W-1:0]    count;

  modport master (
    output enq_miinst, enq_num, stall, flush,
    input  enq_ready, deq_miinst_head, deq_valid, count
  );

  modport slave (
    input  enq_miinst, enq_num, stall, flush,
    output enq_ready, deq_miinst_head, deq_valid, count
  );

endinterface

// File: rtl/miinst_queue_ptr.sv
// rtl/miinst_queue_ptr.sv - head/tail/count/last-PC bookkeeping for the micro-op queue
// Purpose: owns hp, tp, count and last_pc; derives enq_acc and deq_fire.
//   enq_num_i  : requested enqueue slots      enq_ready_o : room for ENQ_N more
//   stall_i    : decode stall                 deq_valid_o : queue non-empty
//   flush_i    : pipeline flush               enq_acc_o   : slots actually written
//   head_pc_i  : pc of mem[hp]                hp_o/tp_o   : head / tail pointers
//                                             count_o     : occupied entries
//                                             last_pc_o   : pc of last consumed entry
module miinst_queue_ptr
  import miinst_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ENQ_N = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int NUM_W = $clog2(ENQ_N + 1),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NUM_W-1:0] enq_num_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  reg_t             head_pc_i,
  output logic             enq_ready_o,
  output logic             deq_valid_o,
  output logic [NUM_W-1:0] enq_acc_o,
  output logic [PTR_W-1:0] hp_o,
  output logic [PTR_W-1:0] tp_o,
  output logic [CNT_W-1:0] count_o,
  output reg_t             last_pc_o
);

  logic [PTR_W-1:0] hp_q, hp_d;
  logic [PTR_W-1:0] tp_q, tp_d;
  logic [CNT_W-1:0] count_q, count_d;
  reg_t             last_pc_q, last_pc_d;
  logic [NUM_W-1:0] enq_acc;
  logic             deq_fire;

  // Ready comes from the registered count only: a pop in the same cycle
  // does not free a slot for the producer until the next cycle.
  assign enq_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_N);
  assign deq_valid_o = (count_q != '0);

  assign enq_acc  = (enq_ready_o && !flush_i) ? enq_num_i : '0;
  assign deq_fire = deq_valid_o && !stall_i && !flush_i;

  always_comb begin
    hp_d      = hp_q;
    tp_d      = tp_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;
    if (flush_i) begin
      // Everything in flight is discarded; the head jumps to the tail so the
      // next enqueue lands exactly at the new head.
      hp_d    = tp_q;
      count_d = '0;
    end else begin
      tp_d    = tp_q + PTR_W'(enq_acc);
      hp_d    = hp_q + PTR_W'(deq_fire);
      count_d = count_q + CNT_W'(enq_acc) - CNT_W'(deq_fire);
      if (deq_fire) begin
        last_pc_d = head_pc_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hp_q      <= '0;
      tp_q      <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      hp_q      <= hp_d;
      tp_q      <= tp_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign enq_acc_o = enq_acc;
  assign hp_o      = hp_q;
  assign tp_o      = tp_q;
  assign count_o   = count_q;
  assign last_pc_o = last_pc_q;

  a_enq_num_legal: assert property (@(posedge clk) disable iff (!rstn)
    enq_num_i <= NUM_W'(ENQ_N))
    else $error("enq_num exceeds ENQ_N");

  a_enq_not_ready: assert property (@(posedge clk) disable iff (!rstn)
    !(enq_num_i != '0 && !enq_ready_o))
    else $warning("enqueue dropped: queue not ready");

  a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
    count_q <= CNT_W'(DEPTH))
    else $error("count exceeds DEPTH");

  a_ptr_consistent: assert property (@(posedge clk) disable iff (!rstn)
    count_q[PTR_W-1:0] == PTR_W'(tp_q - hp_q))
    else $error("pointer distance disagrees with count");

endmodule

// File: rtl/miinst_queue.sv
// rtl/miinst_queue.sv - circular micro-instruction FIFO between translator and decode
// Purpose: accepts up to ENQ_N micro-ops per cycle, presents one head per cycle,
//          and shows nop(last consumed pc) when empty.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : miinst_queue_if.slave (enq_miinst, enq_num, enq_ready, deq_miinst_head,
//          deq_valid, stall, flush, count)
module miinst_queue
  import miinst_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ENQ_N = 2
) (
  input logic           clk,
  input logic           rstn,
  miinst_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NUM_W = $clog2(ENQ_N + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  miinst_t          mem [DEPTH];
  logic [PTR_W-1:0] hp, tp;
  logic [NUM_W-1:0] enq_acc;
  logic [CNT_W-1:0] count;
  logic             enq_ready;
  logic             deq_valid;
  reg_t             last_pc;

  miinst_queue_ptr #(
    .DEPTH (DEPTH),
    .ENQ_N (ENQ_N)
  ) u_ptr (
    .clk         (clk),
    .rstn        (rstn),
    .enq_num_i   (bus.enq_num),
    .stall_i     (bus.stall),
    .flush_i     (bus.flush),
    .head_pc_i   (mem[hp].pc),
    .enq_ready_o (enq_ready),
    .deq_valid_o (deq_valid),
    .enq_acc_o   (enq_acc),
    .hp_o        (hp),
    .tp_o        (tp),
    .count_o     (count),
    .last_pc_o   (last_pc)
  );

  // Storage is not reset: entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_N; i++) begin
      if (i < int'(enq_acc)) begin
        mem[tp + PTR_W'(i)] <= bus.enq_miinst[i];
      end
    end
  end

  assign bus.enq_ready       = enq_ready;
  assign bus.deq_valid       = deq_valid;
  assign bus.count           = count;
  assign bus.deq_miinst_head = deq_valid ? mem[hp] : nop(last_pc);

endmodule

// File: tb/tb_miinst_queue.sv
// tb/tb_miinst_queue.sv - self-checking scoreboard bench for miinst_queue
module tb_miinst_queue;
  import miinst_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int ENQ_N = 2;

  logic clk;
  logic rstn;

  miinst_queue_if #(.DEPTH(DEPTH), .ENQ_N(ENQ_N)) bus ();

  miinst_queue #(.DEPTH(DEPTH), .ENQ_N(ENQ_N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: program-ordered list of resident entries plus last consumed pc.
  miinst_t mq[$];
  miinst_t exp_q[$];
  reg_t    model_last_pc = '0;
  int      snap_cnt = 0;
  reg_t    snap_lpc = '0;
  bit      mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic miinst_t make_inst(input reg_t pc);
    miinst_t m;
    m.op  = uop_e'(4'($urandom_range(1, 5)));
    m.rd  = REG_W'($urandom);
    m.rs  = REG_W'($urandom);
    m.imm = $urandom;
    m.pc  = pc;
    return m;
  endfunction

  // Drive one cycle of inputs just after the rising edge and advance the model
  // by what that edge-to-be must do.
  task automatic drive(input logic st, input logic fl, input int n, input reg_t pc0, input reg_t pc1);
    miinst_t items [ENQ_N];
    bit ready;
    @(posedge clk);
    #1;
    items[0] = make_inst(pc0);
    items[1] = make_inst(pc1);
    for (int i = 0; i < ENQ_N; i++) bus.enq_miinst[i] = items[i];
    bus.enq_num = 2'(n);
    bus.stall   = st;
    bus.flush   = fl;
    snap_cnt = mq.size();
    snap_lpc = model_last_pc;
    ready = (DEPTH - mq.size()) >= ENQ_N;
    if (mq.size() > 0 && !st && !fl) begin
      miinst_t h;
      h = mq.pop_front();
      exp_q.push_back(h);
      model_last_pc = h.pc;
    end
    if (fl) mq.delete();
    else if (ready) for (int i = 0; i < n; i++) mq.push_back(items[i]);
  endtask

  task automatic idle(input logic st);
    drive(st, 1'b0, 0, '0, '0);
  endtask

  // Monitor: compares every cycle against the model snapshot and pops the
  // scoreboard whenever decode actually consumes the head.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && mon_en) begin
        check("mon_count", 128'(bus.count), 128'(snap_cnt));
        check("mon_deq_valid", 128'(bus.deq_valid), 128'(snap_cnt != 0));
        check("mon_enq_ready", 128'(bus.enq_ready), 128'((DEPTH - snap_cnt) >= ENQ_N));
        if (!bus.deq_valid) begin
          check("mon_empty_head", 128'(bus.deq_miinst_head), 128'(nop(snap_lpc)));
        end else if (!bus.stall && !bus.flush) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected_pop: got head pc %0h expected no consumption", bus.deq_miinst_head.pc);
          end else begin
            miinst_t e;
            e = exp_q.pop_front();
            check("mon_head", 128'(bus.deq_miinst_head), 128'(e));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    bus.enq_miinst = '0;
    bus.enq_num = '0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    mon_en = 1'b1;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("rst_deq_valid", 128'(bus.deq_valid), 128'(0));
      check("rst_head", 128'(bus.deq_miinst_head), 128'(nop('0)));
      check("rst_enq_ready", 128'(bus.enq_ready), 128'(1));
      check("rst_count", 128'(bus.count), 128'(0));
    end

    // Two-wide enqueue, then drain
    drive(1'b0, 1'b0, 2, 32'h10, 32'h11);
    idle(1'b0);
    check("pair_head0", 128'(bus.deq_miinst_head.pc), 128'(32'h10));
    check("pair_count", 128'(bus.count), 128'(2));
    idle(1'b0);
    check("pair_head1", 128'(bus.deq_miinst_head.pc), 128'(32'h11));
    idle(1'b0);
    check("pair_empty_head", 128'(bus.deq_miinst_head), 128'(nop(32'h11)));
    check("pair_empty_valid", 128'(bus.deq_valid), 128'(0));

    // Fill under stall to 15, attempt a dropped pair, then drain across the wrap
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 2, reg_t'(2 * k), reg_t'(2 * k + 1));
    drive(1'b1, 1'b0, 1, 32'd14, '0);
    check("fill_ready_at14", 128'(bus.enq_ready), 128'(1));
    check("fill_count14", 128'(bus.count), 128'(14));
    drive(1'b1, 1'b0, 2, 32'h99, 32'h9a);
    check("fill_count15", 128'(bus.count), 128'(15));
    check("fill_ready_at15", 128'(bus.enq_ready), 128'(0));
    idle(1'b1);
    check("fill_drop_count", 128'(bus.count), 128'(15));
    for (int k = 0; k < 16; k++) begin
      idle(1'b0);
      if (k < 15) check("drain_order", 128'(bus.deq_miinst_head.pc), 128'(k));
    end
    check("drain_count", 128'(bus.count), 128'(0));

    // Steady state: one in, one out
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1, reg_t'(32'h100 + k), '0);
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b0, 1, reg_t'(32'h103 + k), '0);
      check("steady_count", 128'(bus.count), 128'(3));
      check("steady_head_pc", 128'(bus.deq_miinst_head.pc), 128'(32'h100 + k));
    end
    repeat (4) idle(1'b0);

    // Flush with six resident entries and a simultaneous enqueue
    drive(1'b0, 1'b0, 2, 32'h40, 32'h41);
    drive(1'b0, 1'b0, 2, 32'h42, 32'h43);
    drive(1'b1, 1'b0, 2, 32'h44, 32'h45);
    drive(1'b1, 1'b0, 1, 32'h46, '0);
    drive(1'b0, 1'b1, 2, 32'h50, 32'h51);
    check("flush_pre_count", 128'(bus.count), 128'(6));
    idle(1'b1);
    check("flush_count", 128'(bus.count), 128'(0));
    check("flush_valid", 128'(bus.deq_valid), 128'(0));
    check("flush_head", 128'(bus.deq_miinst_head), 128'(nop(32'h40)));
    drive(1'b0, 1'b0, 1, 32'h80, '0);
    idle(1'b0);
    check("post_flush_head", 128'(bus.deq_miinst_head.pc), 128'(32'h80));
    check("post_flush_valid", 128'(bus.deq_valid), 128'(1));
    repeat (2) idle(1'b0);

    // Asynchronous reset mid-burst
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 2, reg_t'(32'h60 + 2 * k), reg_t'(32'h61 + 2 * k));
    drive(1'b1, 1'b0, 1, 32'h68, '0);
    idle(1'b1);
    check("burst_count9", 128'(bus.count), 128'(9));
    #2 rstn = 1'b0;
    #1;
    check("async_rst_count", 128'(bus.count), 128'(0));
    check("async_rst_valid", 128'(bus.deq_valid), 128'(0));
    check("async_rst_ready", 128'(bus.enq_ready), 128'(1));
    check("async_rst_head", 128'(bus.deq_miinst_head), 128'(nop('0)));
    mq.delete();
    exp_q.delete();
    model_last_pc = '0;
    snap_cnt = 0;
    snap_lpc = '0;
    bus.enq_num = '0;
    bus.stall = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
    drive(1'b0, 1'b0, 2, 32'h200, 32'h201);
    idle(1'b0);
    check("fresh_head", 128'(bus.deq_miinst_head.pc), 128'(32'h200));
    check("fresh_count", 128'(bus.count), 128'(2));
    repeat (3) idle(1'b0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic st, fl;
      int n;
      st = ($urandom_range(0, 99) < 30);
      fl = ($urandom_range(0, 99) < 3);
      n  = ((DEPTH - mq.size()) >= ENQ_N) ? int'($urandom_range(0, ENQ_N)) : 0;
      drive(st, fl, n, $urandom, $urandom);
    end
    repeat (DEPTH + 2) idle(1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/miinst_queue.md
Name: miinst_queue

Overview:
- Circular micro-instruction FIFO between the x86-to-micro-op translator (fetch side) and decode_phase.
- Accepts up to ENQ_N miinst_t per cycle and presents one head entry per cycle on deq_miinst_head.
- The head is popped when decode consumes it: no stall, no flush.
- Supplies a NOP carrying the last-consumed PC when empty, so decode always latches a well-formed instruction.

Parameters:
- DEPTH, 16: number of entries; power of two, >= 2*ENQ_N.
- ENQ_N, 2: maximum micro-ops enqueued per cycle.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- enq_miinst  in  miinst_t[ENQ_N]  candidate micro-ops; slots 0..enq_num-1 are valid, in program order.
- enq_num  in  $clog2(ENQ_N+1)  number of valid slots this cycle.
- enq_ready  out  1  free entries >= ENQ_N.
- deq_miinst_head  out  miinst_t  head entry, or nop(last_pc) when empty.
- deq_valid  out  1  queue non-empty (head is real).
- stall  in  1  decode stall; head not consumed.
- flush  in  1  pipeline flush (branch mispredict/redirect).
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- State: entry array mem[DEPTH], head pointer hp, tail pointer tp (log2 DEPTH bits, wrap modulo DEPTH), count, last_pc (reg_t).
- Reset (rstn=0, asynchronous): hp=tp=0, count=0, last_pc=0.
  - Outputs during reset: deq_valid=0, enq_ready=1, deq_miinst_head=nop(0).
  - mem contents need not be reset.
- Definitions:
  - deq_fire = deq_valid & ~stall & ~flush.
  - enq_acc = (enq_ready & ~flush) ? enq_num : 0.
- Enqueue: at posedge, mem[tp+i] <= enq_miinst[i] for i < enq_acc; tp <= tp+enq_acc.
  - enq_num > ENQ_N: illegal; simulation assertion.
  - enq_num > 0 with enq_ready=0: dropped with no state change; simulation assertion fires.
  - The producer must hold the instructions.
- Dequeue: on deq_fire, hp <= hp+1 and last_pc <= mem[hp].pc.
- Count: count <= count + enq_acc - deq_fire.
  - Simultaneous enqueue and dequeue are both honoured in the same cycle.
  - Full plus dequeue: enq_ready is computed from the current count, so no same-cycle credit is given for a pop.
- Flush has priority over everything:
  - hp <= tp, count <= 0.
  - Same-cycle enqueue is discarded; no dequeue occurs.
  - last_pc is unchanged.
- Head output (combinational from registers): deq_miinst_head = deq_valid ? mem[hp] : nop(last_pc); deq_valid = (count != 0).
- Latency: an entry enqueued in cycle N is visible at the head in cycle N+1. There is no bypass.
- Wrap-around: pointers wrap silently. Full is count==DEPTH, not hp==tp.
- Reset mid-operation: all in-flight entries are lost immediately and the outputs take their reset values asynchronously.
- Invariant, checked by assertion: count <= DEPTH, and (tp-hp) mod DEPTH == count mod DEPTH.

Decomposition:
- Shared package / common_params_svfiles.h, not this block:
  - miinst_t, reg_t, RIP, REG_N.
  - nop(pc) function returning the NOP miinst_t with the given pc.
- One natural sub-module: miinst_queue_ptr.
  - Holds hp/tp/count and last_pc bookkeeping.
  - Computes enq_acc, deq_fire and the next pointers.
  - Leaves the storage array and head mux in the top.

Test Plan:
- Reset then idle: deq_valid=0, deq_miinst_head=nop(0), enq_ready=1, count=0 for 5 cycles.
- Enqueue {pc=0x10, pc=0x11} with enq_num=2, stall=0:
  - Next cycle head.pc=0x10, count=2.
  - Following cycle head.pc=0x11.
  - Then empty with head=nop(0x11).
- Fill to DEPTH=16 with stall=1:
  - enq_ready drops when count=15.
  - An enq_num=2 attempt at count=15 is dropped (count stays 15).
  - Release stall: entries drain in order pc 0..14, with no loss across pointer wrap.
- Steady state with enq_num=1 and no stall:
  - count stays constant.
  - Head PC increments by 1 per cycle.
  - 40 cycles, so pointers wrap at least twice.
- Flush with count=6 and simultaneous enq_num=2:
  - Next cycle count=0 and deq_valid=0.
  - head=nop(pc of last consumed entry).
  - Subsequent enqueue of pc=0x80 appears at the head one cycle later.
- Assert rstn low asynchronously mid-burst (count=9):
  - Outputs return to reset values before the next clock edge.
  - After release, queue behaves as fresh.
